// File: rtl/digest_uart_serializer.sv
// Streams a captured digest to a byte-wide uart transmitter as ASCII hex, most significant
// nibble first, with an optional CR/LF trailer.
module digest_uart_serializer #(
   parameter int unsigned DIGEST_BITS = 256,
   parameter bit          HEX_UPPER   = 1'b0,
   parameter bit          APPEND_CRLF = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   digest_valid,
   input  logic [DIGEST_BITS-1:0] digest,
   output logic                   ready,
   output logic                   done,
   output logic                   tx_start,
   output logic [7:0]             tx_data,
   input  logic                   tx_busy
);

   localparam int unsigned N  = DIGEST_BITS / 4;
   localparam int unsigned T  = N + (APPEND_CRLF ? 2 : 0);
   localparam int unsigned IW = $clog2(T + 1);

   localparam logic [IW-1:0] NIdx    = IW'(N);
   localparam logic [IW-1:0] LastIdx = IW'(T - 1);
   localparam logic [7:0]    AlphaA  = HEX_UPPER ? 8'h41 : 8'h61;

   typedef enum logic [2:0] {
      StIdle,
      StSend,
      StWaitHi,
      StWaitLo,
      StDone
   } state_e;

   state_e                 state_q, state_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [DIGEST_BITS-1:0] digest_q, digest_d;
   logic                   tx_start_q, tx_start_d;
   logic [7:0]             tx_data_q, tx_data_d;
   logic [3:0]             nib;
   logic [7:0]             char_cur;

   // Nibble select as a constant-index mux over the captured digest.
   always_comb begin
      nib = 4'h0;
      for (int k = 0; k < int'(N); k++) begin
         if (idx_q == IW'(k)) begin
            nib = digest_q[DIGEST_BITS-1-4*k -: 4];
         end
      end
   end

   always_comb begin
      char_cur = 8'h00;
      if (idx_q == NIdx) begin
         char_cur = 8'h0D;
      end else if (idx_q > NIdx) begin
         char_cur = 8'h0A;
      end else if (nib < 4'd10) begin
         char_cur = 8'h30 + {4'h0, nib};
      end else begin
         char_cur = AlphaA + {4'h0, nib} - 8'd10;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      digest_d   = digest_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      unique case (state_q)
         StIdle: begin
            if (digest_valid) begin
               digest_d = digest;
               idx_d    = '0;
               state_d  = StSend;
            end
         end
         StSend: begin
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = char_cur;
               state_d    = StWaitHi;
            end
         end
         StWaitHi: begin
            if (tx_busy) begin
               state_d = StWaitLo;
            end
         end
         StWaitLo: begin
            if (!tx_busy) begin
               if (idx_q == LastIdx) begin
                  state_d = StDone;
               end else begin
                  idx_d   = idx_q + IW'(1);
                  state_d = StSend;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         digest_q   <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         digest_q   <= digest_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign ready    = (state_q == StIdle);
   assign done     = (state_q == StDone);
   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_digest_uart_serializer.sv
// Scoreboard bench: three serializer variants share the digest stimulus, each driving its own
// uart model; a monitor compares every character and handshake against a reference model.
module tb_digest_uart_serializer;

   localparam int DB    = 256;
   localparam int N     = DB / 4;
   localparam int FRAME = 100;
   localparam int NI    = 3;

   logic          clk          = 1'b0;
   logic          rst_n        = 1'b0;
   logic          digest_valid = 1'b0;
   logic          force_busy   = 1'b0;
   logic [DB-1:0] digest       = '0;
   logic [NI-1:0] ready, done, tx_start, busy_eff;
   logic [NI-1:0] uart_busy    = '0;
   logic [7:0]    tx_data [NI];

   bit upper [NI] = '{1'b0, 1'b1, 1'b0};
   bit crlf  [NI] = '{1'b1, 1'b1, 1'b0};

   assign busy_eff = uart_busy | {NI{force_busy}};

   always #5 clk = ~clk;

   digest_uart_serializer #(.DIGEST_BITS(DB), .HEX_UPPER(1'b0), .APPEND_CRLF(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n), .digest_valid(digest_valid), .digest(digest),
      .ready(ready[0]), .done(done[0]), .tx_start(tx_start[0]), .tx_data(tx_data[0]),
      .tx_busy(busy_eff[0]));
   digest_uart_serializer #(.DIGEST_BITS(DB), .HEX_UPPER(1'b1), .APPEND_CRLF(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .digest_valid(digest_valid), .digest(digest),
      .ready(ready[1]), .done(done[1]), .tx_start(tx_start[1]), .tx_data(tx_data[1]),
      .tx_busy(busy_eff[1]));
   digest_uart_serializer #(.DIGEST_BITS(DB), .HEX_UPPER(1'b0), .APPEND_CRLF(1'b0)) dut2 (
      .clk(clk), .rst_n(rst_n), .digest_valid(digest_valid), .digest(digest),
      .ready(ready[2]), .done(done[2]), .tx_start(tx_start[2]), .tx_data(tx_data[2]),
      .tx_busy(busy_eff[2]));

   // Uart model: busy rises the cycle after tx_start and stays high for FRAME cycles.
   int frm_cnt [NI] = '{default: 0};
   always @(posedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (frm_cnt[i] != 0) begin
            frm_cnt[i] <= frm_cnt[i] - 1;
            if (frm_cnt[i] == 1) uart_busy[i] <= 1'b0;
         end else if (tx_start[i]) begin
            frm_cnt[i]   <= FRAME;
            uart_busy[i] <= 1'b1;
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input bit ok, input string name, input int inst, input longint act,
                      input longint exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s inst%0d t=%0t: got %0h want %0h", name, inst, $time, act, exp);
      end
   endtask

   // Scoreboard state, one lane per instance.
   logic [7:0] exp_q [NI][$];
   bit         model_idle [NI] = '{default: 1'b1};
   bit         idle_next  [NI] = '{default: 1'b0};
   bit         active     [NI] = '{default: 1'b0};
   bit         first      [NI] = '{default: 1'b0};
   int         acc_cyc    [NI] = '{default: 0};
   int         send_ok    [NI] = '{default: -1};
   int         fall_cyc   [NI] = '{default: -10};
   int         last_start [NI] = '{default: -1};
   int         issued     [NI] = '{default: 0};
   logic       prev_busy  [NI] = '{default: 1'b0};
   logic [7:0] last_data  [NI] = '{default: 8'h00};
   int         cyc = 0;

   task automatic push_model(input int i, input logic [DB-1:0] d);
      int nib;
      for (int k = 0; k < N; k++) begin
         nib = int'(d[DB-1-4*k -: 4]);
         if (nib < 10) exp_q[i].push_back(8'(48 + nib));
         else          exp_q[i].push_back(8'((upper[i] ? 65 : 97) + nib - 10));
      end
      if (crlf[i]) begin
         exp_q[i].push_back(8'h0D);
         exp_q[i].push_back(8'h0A);
      end
   endtask

   always @(negedge clk) begin
      bit         done_exp;
      logic [7:0] e;
      cyc++;
      for (int i = 0; i < NI; i++) begin
         if (!rst_n) begin
            exp_q[i].delete();
            model_idle[i] = 1'b1;
            idle_next[i]  = 1'b0;
            active[i]     = 1'b0;
            first[i]      = 1'b0;
            last_data[i]  = 8'h00;
            if (prev_busy[i] && !busy_eff[i]) fall_cyc[i] = cyc;
            prev_busy[i]  = busy_eff[i];
         end else begin
            if (idle_next[i]) begin
               model_idle[i] = 1'b1;
               idle_next[i]  = 1'b0;
            end
            chk(ready[i] == model_idle[i], "ready", i, ready[i], model_idle[i]);
            chk(!(ready[i] && done[i]), "done_with_ready", i, done[i], 0);
            done_exp = active[i] && exp_q[i].size() == 0 && fall_cyc[i] == cyc - 1 &&
                       fall_cyc[i] > last_start[i];
            if (active[i] || done[i]) chk(done[i] == done_exp, "done", i, done[i], done_exp);
            if (done_exp) begin
               active[i]    = 1'b0;
               idle_next[i] = 1'b1;
            end
            if (prev_busy[i] && !busy_eff[i]) fall_cyc[i] = cyc;
            prev_busy[i] = busy_eff[i];
            if (tx_start[i]) begin
               chk(exp_q[i].size() != 0, "extra_start", i, issued[i], exp_q[i].size());
               if (exp_q[i].size() != 0) begin
                  e = exp_q[i].pop_front();
                  chk(tx_data[i] == e, "char", i, tx_data[i], e);
               end
               chk(!busy_eff[i] && (first[i] || fall_cyc[i] > last_start[i]), "start_spacing",
                   i, busy_eff[i], 0);
               if (first[i]) begin
                  chk(send_ok[i] >= 0 && cyc == send_ok[i] + 1, "first_latency", i,
                      cyc - acc_cyc[i], send_ok[i] + 1 - acc_cyc[i]);
                  first[i] = 1'b0;
               end
               last_start[i] = cyc;
               issued[i]++;
            end else begin
               chk(tx_data[i] == last_data[i], "data_hold", i, tx_data[i], last_data[i]);
            end
            last_data[i] = tx_data[i];
            if (first[i] && send_ok[i] < 0 && cyc > acc_cyc[i] && !busy_eff[i]) send_ok[i] = cyc;
            if (digest_valid && model_idle[i]) begin
               push_model(i, digest);
               active[i]     = 1'b1;
               model_idle[i] = 1'b0;
               first[i]      = 1'b1;
               send_ok[i]    = -1;
               acc_cyc[i]    = cyc;
               issued[i]     = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_all_ready(input string name);
      int n = 0;
      while (ready != {NI{1'b1}} && n < 20000) begin
         tick();
         n++;
      end
      chk(n < 20000, name, 0, n, 20000);
   endtask

   task automatic wait_issued(input int cnt);
      int n = 0;
      while (issued[0] < cnt && n < 20000) begin
         tick();
         n++;
      end
      chk(n < 20000, "issue_timeout", 0, issued[0], cnt);
   endtask

   function automatic logic [DB-1:0] rand_digest();
      logic [DB-1:0] r;
      for (int j = 0; j < DB / 32; j++) r[32*j +: 32] = $urandom;
      return r;
   endfunction

   task automatic send(input logic [DB-1:0] d);
      wait_all_ready("idle_timeout");
      digest       = d;
      digest_valid = 1'b1;
      tick();
      digest_valid = 1'b0;
      digest       = rand_digest();
   endtask

   task automatic check_reset_outputs();
      for (int i = 0; i < NI; i++) begin
         chk(tx_start[i] == 1'b0, "rst_tx_start", i, tx_start[i], 0);
         chk(ready[i] == 1'b1, "rst_ready", i, ready[i], 1);
         chk(done[i] == 1'b0, "rst_done", i, done[i], 0);
         chk(tx_data[i] == 8'h00, "rst_tx_data", i, tx_data[i], 0);
      end
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) tick();
      check_reset_outputs();
      rst_n = 1'b1;
      tick();

      send('0);
      send(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
      send({DB{1'b1}});

      // Competing request mid-stream must be ignored.
      send(rand_digest());
      wait_issued(11);
      digest       = rand_digest();
      digest_valid = 1'b1;
      tick();
      digest_valid = 1'b0;

      // Busy already high when the digest is accepted.
      wait_all_ready("idle_timeout");
      force_busy = 1'b1;
      send(rand_digest());
      repeat (49) tick();
      force_busy = 1'b0;

      // Reset while waiting for the 21st frame to finish.
      send(rand_digest());
      wait_issued(21);
      repeat (20) tick();
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      send(rand_digest());

      // digest_valid held high across a stream: next digest taken as ready returns.
      wait_all_ready("idle_timeout");
      digest       = rand_digest();
      digest_valid = 1'b1;
      tick();
      digest = rand_digest();
      n = 0;
      while (!done[0] && n < 20000) begin
         tick();
         n++;
      end
      chk(n < 20000, "done_timeout", 0, n, 20000);
      n = 0;
      tick();
      while (ready[0] && n < 10) begin
         tick();
         n++;
      end
      digest_valid = 1'b0;

      wait_all_ready("idle_timeout");
      repeat (5) tick();
      for (int i = 0; i < NI; i++) begin
         chk(exp_q[i].size() == 0, "queue_empty", i, exp_q[i].size(), 0);
         chk(model_idle[i] == 1'b1, "end_idle", i, model_idle[i], 1);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
